hsid_x_reg_arb: RTL and testbench
=================================

HSID_X_REG_ARB -- requirements
Module: hsid_x_reg_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of BUSY cycles to wait for slv_rsp_i.ready (0 = timeout disabled).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the timeout counter width; TIMEOUT_CYCLES SHALL be less than 2**CNT_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_i  input  hsid_x_reg_pkg::reg_req_t  requester 0 (host) request: valid, write, wstrb[3:0], addr[31:0], wdata[31:0].
REQ-006 rsp0_o  output  hsid_x_reg_pkg::reg_rsp_t  requester 0 response: ready, error, rdata[31:0].
REQ-007 req1_i  input  hsid_x_reg_pkg::reg_req_t  requester 1 (internal/debug) request.
REQ-008 rsp1_o  output  hsid_x_reg_pkg::reg_rsp_t  requester 1 response.
REQ-009 slv_req_o  output  hsid_x_reg_pkg::reg_req_t  request to the shared register slave.
REQ-010 slv_rsp_i  input  hsid_x_reg_pkg::reg_rsp_t  response from the shared register slave.
REQ-011 busy_o  output  1  high while in BUSY.
REQ-012 grant_o  output  2  one-hot owner of the current transaction; 00 in IDLE.
REQ-013 timeout_o  output  1  single-cycle pulse on a timeout completion.

Function
REQ-014 SHALL implement a 2-state FSM: IDLE and BUSY.
REQ-015 IDLE: if any reqN_i.valid = 1, register the winner into grant, clear the counter, and enter BUSY next cycle; otherwise remain in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both valid, the requester not served by the last completed transaction wins; after reset, requester 0 has priority.
REQ-017 BUSY: slv_req_o SHALL equal the granted requester's request fields with valid = 1; in IDLE, slv_req_o SHALL be all-zero.
REQ-018 Requesters SHALL hold valid and all fields stable until they see ready; the arbiter SHALL NOT latch the request fields.
REQ-019 BUSY with slv_rsp_i.ready = 1: drive the granted rspN_o = slv_rsp_i in the same cycle (combinational), record the last winner, and return to IDLE.
REQ-020 Minimum transaction latency SHALL be 2 cycles from valid (IDLE sample plus BUSY with ready); at least one IDLE cycle SHALL occur between transactions.
REQ-021 The non-granted rsp, and both rsp outputs in IDLE, SHALL be all-zero.
REQ-022 Counter SHALL increment each BUSY cycle without ready, saturating at 2**CNT_W-1.
REQ-023 If TIMEOUT_CYCLES > 0 and the counter equals TIMEOUT_CYCLES with slv_rsp_i.ready = 0: drive the granted rsp with ready = 1, error = 1, rdata = 32'h0; drive slv_req_o.valid = 0; pulse timeout_o; update the last winner; return to IDLE.
REQ-024 slv_rsp_i.ready in the same cycle as the timeout condition SHALL take precedence: normal completion, no timeout_o.
REQ-025 If the granted requester drops valid while in BUSY: return to IDLE without any response, leave the last winner unchanged, and drive slv_req_o.valid = 0 in that cycle.
REQ-026 slv_rsp_i SHALL be ignored in IDLE.
REQ-027 Write/read type, wstrb and error SHALL pass through unmodified; no width conversion.

Reset
REQ-028 While rst = 1: state = IDLE, grant = 00, counter = 0, last winner = requester 1 (so requester 0 wins first), timeout_o = 0.
REQ-029 During and after reset, all outputs SHALL be zero; a transaction in progress at reset is dropped with no response.

Verification
REQ-030 Single read: req0 valid, addr 0x10, slave ready 1 cycle after valid_o, rdata 0xA5A5_0001 -> rsp0_o.ready = 1 with rdata 0xA5A5_0001 in BUSY cycle 1; rsp1_o = 0; grant_o = 01.
REQ-031 Contention: req0 and req1 valid together, slave always ready -> order 0,1,0,1 across four transactions; one IDLE cycle between each.
REQ-032 Timeout: TIMEOUT_CYCLES = 4, slave never ready, req1 write -> rsp1_o ready = 1, error = 1 on the 5th BUSY cycle; timeout_o pulses once; next req0 is granted.
REQ-033 Race: TIMEOUT_CYCLES = 4, slave ready on the timeout cycle with error = 0 -> normal completion, timeout_o = 0.
REQ-034 Abort and reset: req0 drops valid in BUSY -> IDLE next cycle, no response; rst asserted mid-BUSY -> outputs 0 next cycle, req0 wins the first grant after reset.

Source files
------------

// File: rtl/hsid_x_reg_pkg.sv
// Register-bus request/response types shared by the arbiter, its interface and the bench.
package hsid_x_reg_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } reg_rsp_t;

endpackage

// File: rtl/hsid_x_reg_arb_if.sv
// Bundle of the two requester ports, the shared slave port and arbiter status.
interface hsid_x_reg_arb_if;

  hsid_x_reg_pkg::reg_req_t req0_i;
  hsid_x_reg_pkg::reg_rsp_t rsp0_o;
  hsid_x_reg_pkg::reg_req_t req1_i;
  hsid_x_reg_pkg::reg_rsp_t rsp1_o;
  hsid_x_reg_pkg::reg_req_t slv_req_o;
  hsid_x_reg_pkg::reg_rsp_t slv_rsp_i;
  logic                     busy_o;
  logic [1:0]               grant_o;
  logic                     timeout_o;

  // master: the arbiter itself; slave: whatever surrounds it
  modport master (
    input  req0_i, req1_i, slv_rsp_i,
    output rsp0_o, rsp1_o, slv_req_o, busy_o, grant_o, timeout_o
  );

  modport slave (
    output req0_i, req1_i, slv_rsp_i,
    input  rsp0_o, rsp1_o, slv_req_o, busy_o, grant_o, timeout_o
  );

endinterface

// File: rtl/hsid_x_reg_arb.sv
// Two-requester round-robin arbiter onto one register slave, with abort and
// optional response timeout. Request fields are never latched, only the owner.
module hsid_x_reg_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  hsid_x_reg_arb_if.master        bus
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TimeoutEn  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q;
  logic [1:0]       grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;   // 1: requester 1 won the last completed transaction

  hsid_x_reg_pkg::reg_req_t req_g;
  hsid_x_reg_pkg::reg_rsp_t rsp_g;
  logic in_busy, abort, done, tmo, win1;

  always_comb begin
    req_g   = grant_q[1] ? bus.req1_i : bus.req0_i;
    // Outputs are forced quiet while reset is held, not just after it is sampled.
    in_busy = (state_q == StBusy) && !rst;
    abort   = in_busy && !req_g.valid;
    done    = in_busy && req_g.valid && bus.slv_rsp_i.ready;
    tmo     = in_busy && req_g.valid && !bus.slv_rsp_i.ready && TimeoutEn &&
              (cnt_q == TimeoutVal);
    win1    = bus.req1_i.valid && (!bus.req0_i.valid || !last_q);

    rsp_g = '0;
    if (done) begin
      rsp_g = bus.slv_rsp_i;
    end else if (tmo) begin
      rsp_g.ready = 1'b1;
      rsp_g.error = 1'b1;
    end

    bus.slv_req_o = '0;
    if (in_busy) begin
      bus.slv_req_o       = req_g;
      bus.slv_req_o.valid = req_g.valid && !tmo;
    end

    bus.rsp0_o    = grant_q[0] ? rsp_g : '0;
    bus.rsp1_o    = grant_q[1] ? rsp_g : '0;
    bus.busy_o    = in_busy;
    bus.grant_o   = in_busy ? grant_q : 2'b00;
    bus.timeout_o = tmo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req0_i.valid || bus.req1_i.valid) begin
            state_q <= StBusy;
            grant_q <= win1 ? 2'b10 : 2'b01;
            cnt_q   <= '0;
          end
        end
        StBusy: begin
          if (abort || done || tmo) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            if (!abort) last_q <= grant_q[1];
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsid_x_reg_arb.sv
// Bench for hsid_x_reg_arb: directed vector table, hand sequences for abort/reset,
// then randomized traffic against a transaction-level reference model.
module tb_hsid_x_reg_arb;
  import hsid_x_reg_pkg::*;

  localparam int Tmo = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hsid_x_reg_arb_if bus ();

  hsid_x_reg_arb #(.TIMEOUT_CYCLES(Tmo), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    reg_rsp_t   rsp0;
    reg_rsp_t   rsp1;
    reg_req_t   slv_req;
    logic       busy;
    logic [1:0] grant;
    logic       tmo;
  } out_t;

  typedef struct {
    logic rst, v0, v1, w1, rdy, rerr;
    logic [31:0] rdata;
    logic e_busy;
    logic [1:0] e_grant;
    logic e_r0rdy, e_r1rdy, e_err;
    logic [31:0] e_rdata;
    logic e_sv, e_tmo;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: owner -1 means nobody holds the slave.
  int m_owner = -1;
  int m_wait  = 0;
  int m_last  = 1;

  function automatic reg_req_t req0_of(logic v);
    reg_req_t r;
    r = '0;
    r.valid = v;
    r.addr  = 32'h10;
    return r;
  endfunction

  function automatic reg_req_t req1_of(logic v, logic w);
    reg_req_t r;
    r.valid = v;
    r.write = w;
    r.wstrb = 4'hF;
    r.addr  = 32'h20;
    r.wdata = 32'hDEAD_BEEF;
    return r;
  endfunction

  function automatic vec_t mk(logic r, logic v0, logic v1, logic w1, logic rdy, logic rerr,
                             logic [31:0] rdata, logic eb, logic [1:0] eg, logic e0, logic e1,
                             logic ee, logic [31:0] ed, logic esv, logic et);
    vec_t v;
    v.rst = r; v.v0 = v0; v.v1 = v1; v.w1 = w1; v.rdy = rdy; v.rerr = rerr; v.rdata = rdata;
    v.e_busy = eb; v.e_grant = eg; v.e_r0rdy = e0; v.e_r1rdy = e1; v.e_err = ee;
    v.e_rdata = ed; v.e_sv = esv; v.e_tmo = et;
    return v;
  endfunction

  function automatic out_t sample();
    out_t s;
    s.rsp0    = bus.rsp0_o;
    s.rsp1    = bus.rsp1_o;
    s.slv_req = bus.slv_req_o;
    s.busy    = bus.busy_o;
    s.grant   = bus.grant_o;
    s.tmo     = bus.timeout_o;
    return s;
  endfunction

  function automatic out_t model_out();
    out_t     o;
    reg_req_t r;
    reg_rsp_t t;
    o = '0;
    if (rst || m_owner < 0) return o;
    r = (m_owner == 1) ? bus.req1_i : bus.req0_i;
    o.busy    = 1'b1;
    o.grant   = (m_owner == 1) ? 2'b10 : 2'b01;
    o.slv_req = r;
    t = '0;
    if (r.valid && bus.slv_rsp_i.ready) begin
      t = bus.slv_rsp_i;
    end else if (r.valid && Tmo != 0 && m_wait == Tmo) begin
      t.ready = 1'b1;
      t.error = 1'b1;
      o.slv_req.valid = 1'b0;
      o.tmo = 1'b1;
    end
    if (m_owner == 1) o.rsp1 = t;
    else              o.rsp0 = t;
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1;
      m_wait  <= 0;
      m_last  <= 1;
    end else if (m_owner < 0) begin
      if (bus.req0_i.valid || bus.req1_i.valid) begin
        if (bus.req0_i.valid && bus.req1_i.valid) m_owner <= 1 - m_last;
        else                                      m_owner <= bus.req0_i.valid ? 0 : 1;
        m_wait <= 0;
      end
    end else if (!((m_owner == 1) ? bus.req1_i.valid : bus.req0_i.valid)) begin
      m_owner <= -1;
    end else if (bus.slv_rsp_i.ready || (Tmo != 0 && m_wait == Tmo)) begin
      m_last  <= m_owner;
      m_owner <= -1;
    end else if (m_wait < 255) begin
      m_wait <= m_wait + 1;
    end
  end

  task automatic chk(string name, logic [159:0] got, logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(string name, out_t exp);
    @(negedge clk);
    chk(name, 160'(sample()), 160'(exp));
    tick();
  endtask

  task automatic apply_model(string name);
    @(negedge clk);
    chk(name, 160'(sample()), 160'(model_out()));
    tick();
  endtask

  vec_t tbl[27];

  initial begin
    out_t     exp;
    reg_req_t rq;
    logic     v0, v1;

    rst = 1'b1;
    bus.req0_i = '0;
    bus.req1_i = '0;
    bus.slv_rsp_i = '0;

    tbl[0]  = mk(1,0,0,0,0,0,32'h0,        0,2'b00,0,0,0,32'h0,        0,0);
    tbl[1]  = mk(1,0,0,0,0,0,32'h0,        0,2'b00,0,0,0,32'h0,        0,0);
    tbl[2]  = mk(0,1,0,0,0,0,32'h0,        0,2'b00,0,0,0,32'h0,        0,0);
    tbl[3]  = mk(0,1,0,0,1,0,32'hA5A5_0001,1,2'b01,1,0,0,32'hA5A5_0001,1,0);
    tbl[4]  = mk(0,0,0,0,0,0,32'h0,        0,2'b00,0,0,0,32'h0,        0,0);
    tbl[5]  = mk(1,0,0,0,0,0,32'h0,        0,2'b00,0,0,0,32'h0,        0,0);
    tbl[6]  = mk(0,1,1,0,1,0,32'h1,        0,2'b00,0,0,0,32'h0,        0,0);
    tbl[7]  = mk(0,1,1,0,1,0,32'h1,        1,2'b01,1,0,0,32'h1,        1,0);
    tbl[8]  = mk(0,1,1,0,1,0,32'h2,        0,2'b00,0,0,0,32'h0,        0,0);
    tbl[9]  = mk(0,1,1,0,1,1,32'h2,        1,2'b10,0,1,1,32'h2,        1,0);
    tbl[10] = mk(0,1,1,0,1,0,32'h3,        0,2'b00,0,0,0,32'h0,        0,0);
    tbl[11] = mk(0,1,1,0,1,0,32'h3,        1,2'b01,1,0,0,32'h3,        1,0);
    tbl[12] = mk(0,1,1,0,1,0,32'h4,        0,2'b00,0,0,0,32'h0,        0,0);
    tbl[13] = mk(0,1,1,0,1,0,32'h4,        1,2'b10,0,1,0,32'h4,        1,0);
    tbl[14] = mk(0,0,1,1,0,0,32'h0,        0,2'b00,0,0,0,32'h0,        0,0);
    for (int i = 15; i < 19; i++)
      tbl[i] = mk(0,0,1,1,0,0,32'h0,       1,2'b10,0,0,0,32'h0,        1,0);
    tbl[19] = mk(0,0,1,1,0,0,32'h0,        1,2'b10,0,1,1,32'h0,        0,1);
    tbl[20] = mk(0,1,1,1,0,0,32'h0,        0,2'b00,0,0,0,32'h0,        0,0);
    for (int i = 21; i < 25; i++)
      tbl[i] = mk(0,1,1,1,0,0,32'h0,       1,2'b01,0,0,0,32'h0,        1,0);
    tbl[25] = mk(0,1,1,1,1,0,32'h55,       1,2'b01,1,0,0,32'h55,       1,0);
    tbl[26] = mk(0,0,0,0,0,0,32'h0,        0,2'b00,0,0,0,32'h0,        0,0);

    for (int i = 0; i < 27; i++) begin
      rst = tbl[i].rst;
      bus.req0_i = req0_of(tbl[i].v0);
      bus.req1_i = req1_of(tbl[i].v1, tbl[i].w1);
      bus.slv_rsp_i.ready = tbl[i].rdy;
      bus.slv_rsp_i.error = tbl[i].rerr;
      bus.slv_rsp_i.rdata = tbl[i].rdata;
      exp = '0;
      if (tbl[i].e_busy) begin
        exp.busy    = 1'b1;
        exp.grant   = tbl[i].e_grant;
        exp.slv_req = (tbl[i].e_grant == 2'b01) ? req0_of(1'b1) : req1_of(1'b1, tbl[i].w1);
        exp.slv_req.valid = tbl[i].e_sv;
      end
      if (tbl[i].e_r0rdy) exp.rsp0 = '{ready: 1'b1, error: tbl[i].e_err, rdata: tbl[i].e_rdata};
      if (tbl[i].e_r1rdy) exp.rsp1 = '{ready: 1'b1, error: tbl[i].e_err, rdata: tbl[i].e_rdata};
      exp.tmo = tbl[i].e_tmo;
      apply($sformatf("table[%0d]", i), exp);
    end

    // Abort: owner drops valid mid-transaction; last winner (req0) must be kept.
    bus.slv_rsp_i = '0;
    bus.req0_i = req0_of(1'b1);
    bus.req1_i = req1_of(1'b0, 1'b0);
    @(negedge clk);
    chk("abort_pre_idle", 160'(bus.busy_o), 160'(0));
    tick();
    @(negedge clk);
    chk("abort_grant", 160'(bus.grant_o), 160'(2'b01));
    bus.req0_i = req0_of(1'b0);
    #1;
    chk("abort_slv_valid", 160'(bus.slv_req_o.valid), 160'(0));
    chk("abort_no_rsp", 160'(bus.rsp0_o), 160'(0));
    tick();
    @(negedge clk);
    chk("abort_idle_next", 160'({bus.busy_o, bus.grant_o}), 160'(0));
    bus.req0_i = req0_of(1'b1);
    bus.req1_i = req1_of(1'b1, 1'b0);
    tick();
    @(negedge clk);
    chk("abort_last_kept", 160'(bus.grant_o), 160'(2'b10));

    // Reset in the middle of a busy transaction.
    rst = 1'b1;
    #1;
    chk("rst_during", 160'(sample()), 160'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_idle", 160'(sample()), 160'(0));
    tick();
    @(negedge clk);
    chk("rst_first_grant", 160'(bus.grant_o), 160'(2'b01));
    tick();

    // Random traffic; valids persist so timeouts and contention both occur.
    v0 = 1'b1;
    v1 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) v0 = ~v0;
      if ($urandom_range(7) == 0) v1 = ~v1;
      rst = ($urandom_range(199) == 0);
      rq = {$urandom, $urandom, $urandom};
      rq.valid = v0;
      bus.req0_i = rq;
      rq = {$urandom, $urandom, $urandom};
      rq.valid = v1;
      bus.req1_i = rq;
      bus.slv_rsp_i.ready = ($urandom_range(7) == 0);
      bus.slv_rsp_i.error = 1'($urandom);
      bus.slv_rsp_i.rdata = $urandom;
      apply_model($sformatf("rand[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
